bmem_line_adapter: RTL and testbench
====================================

// Module: bmem_line_adapter
// PURPOSE
//  Bridges I-cache and D-cache 256-bit line requests onto the single 64-bit banked-memory port (bmem_*).
//  Serialises line writes into 4 beats and reassembles line reads from 4 tagged beats.
//  Keeps up to one outstanding read per client, so I and D misses overlap in memory.
//  Sits between the cache pair inside cpu and the banked_memory model.
// PARAMETERS
//  ADDR_BITS  32   byte address width
//  LINE_BITS  256  cache line width
//  BEAT_BITS  64   bmem data width; BEATS = LINE_BITS/BEAT_BITS = 4
// PORTS
//  clk           in   1    clock, all state on posedge
//  rst           in   1    synchronous, active-high reset
//  icache_addr   in   32   I line address; bits[4:0] ignored (treated as 0)
//  icache_read   in   1    I line read request, held until icache_resp
//  icache_rdata  out  256  I line data, valid while icache_resp=1
//  icache_resp   out  1    one-cycle I completion pulse
//  dcache_addr   in   32   D line address; bits[4:0] ignored
//  dcache_read   in   1    D line read request, held until dcache_resp
//  dcache_write  in   1    D line write request, held until dcache_resp; never with dcache_read
//  dcache_wdata  in   256  D write line; beat k = bits[64k+63:64k]
//  dcache_rdata  out  256  D line data, valid while dcache_resp=1
//  dcache_resp   out  1    one-cycle D completion pulse (read or write)
//  bmem_addr     out  32   line-aligned request address
//  bmem_read     out  1    read request; accepted in a cycle with bmem_ready=1
//  bmem_write    out  1    write beat valid; beat consumed in a cycle with bmem_ready=1
//  bmem_wdata    out  64   current write beat
//  bmem_ready    in   1    memory can accept read/write this cycle
//  bmem_raddr    in   32   line address of returning beat
//  bmem_rdata    in   64   returning beat data
//  bmem_rvalid   in   1    returning beat valid
// BEHAVIOUR
//  Reset: all outputs 0. Both channels go IDLE. Beat counters and perf counters clear.
//   Any rvalid beat after reset matches no outstanding read and is dropped.
//  Per-channel FSM: IDLE -> ISSUE -> WAIT (reads) | WBEAT (D writes) -> RESP -> IDLE.
//   IDLE->ISSUE: request seen and no hazard; latch line address.
//   ISSUE: channel competes for the bmem port; grant + bmem_ready -> WAIT, else hold.
//   WAIT: on rvalid && bmem_raddr==latched addr, write beat into slot cnt, cnt++.
//    Beats of one line arrive in order. After beat 3 -> RESP.
//   WBEAT: bmem_write=1, bmem_addr held, bmem_wdata=beat cnt; cnt++ on bmem_ready.
//    After beat 3 consumed -> RESP. Write grant is held for all 4 beats; no read interleaves.
//   RESP: resp=1 and rdata valid for exactly 1 cycle -> IDLE.
//    Request input is ignored in the RESP cycle and the cycle after.
//  Arbitration of the bmem request port: registered outputs; one grant per cycle.
//   Both ISSUE in the same cycle: the channel not granted last wins (alternating). Reset favours D.
//  Latency, idle memory with ready=1: request sampled at cycle N; bmem_read at N+1.
//   resp is the cycle after the 4th beat is captured.
//  Hazards:
//   New request whose line == the other channel's outstanding read or write line waits in IDLE until that channel leaves RESP.
//   This prevents ambiguous raddr matching and read/write reordering.
//  rvalid beats whose raddr matches neither channel in WAIT are dropped. There is no error flag.
//  I and D reads may both be in WAIT. Each captures only its own tagged beats; interleaving is allowed.
//  Read and write lines are always 32-byte aligned; bits[4:0] of bmem_addr are always 0.
// CONFIGURATION
//  BMEM_PERF_CNT_EN defined: adds two 32-bit saturating internal counters, read hierarchically by the bench.
//   num_icache_wait_cycles: +1 each cycle the I channel is not IDLE.
//   num_dcache_wait_cycles: +1 each cycle the D channel is not IDLE.
//  Not defined: the counters are absent. Ports and timing are identical.
// TESTING
//  1. I read 0x0000_1000, ready=1, beats A,B,C,D arrive 3 cycles later.
//     -> icache_rdata={D,C,B,A}, resp one cycle after D.
//  2. D write 0x2000, wdata beats 0..3, ready low on 2nd beat for 2 cycles.
//     -> 4 bmem_write beats in order, beat 1 held 2 cycles, dcache_resp after beat 3.
//  3. I read 0x1000 and D read 0x3000 in the same cycle; beats returned interleaved I,D,I,D...
//     -> D issued first (post-reset), each client gets only its own line.
//  4. I read 0x4000 outstanding; D write 0x4000 raised.
//     -> write waits until icache_resp, then issues.
//  5. Reset asserted after 2 beats of a read; stale beats arrive after reset.
//     -> no resp, outputs 0, next read completes with correct data.
//  6. BMEM_PERF_CNT_EN defined, scenario 1.
//     -> num_icache_wait_cycles equals cycles from request to resp inclusive.

Source files
------------

// File: rtl/bmem_line_adapter.sv
// Two-client cache line adapter: I/D 256-bit line requests onto one 64-bit beat-serial memory port.
// Optional macro BMEM_PERF_CNT_EN adds saturating per-channel wait-cycle counters.
`timescale 1ns/1ps

module bmem_line_adapter #(
    parameter int ADDR_BITS = 32,
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] icache_addr,
    input  logic                 icache_read,
    output logic [LINE_BITS-1:0] icache_rdata,
    output logic                 icache_resp,
    input  logic [ADDR_BITS-1:0] dcache_addr,
    input  logic                 dcache_read,
    input  logic                 dcache_write,
    input  logic [LINE_BITS-1:0] dcache_wdata,
    output logic [LINE_BITS-1:0] dcache_rdata,
    output logic                 dcache_resp,
    output logic [ADDR_BITS-1:0] bmem_addr,
    output logic                 bmem_read,
    output logic                 bmem_write,
    output logic [BEAT_BITS-1:0] bmem_wdata,
    input  logic                 bmem_ready,
    input  logic [ADDR_BITS-1:0] bmem_raddr,
    input  logic [BEAT_BITS-1:0] bmem_rdata,
    input  logic                 bmem_rvalid
);
    // state | meaning
    // IDLE  | no request in flight
    // ISSUE | competing for the bmem request port
    // WAIT  | read accepted, collecting tagged beats
    // WBEAT | D write owns the port, streaming beats
    // RESP  | one-cycle completion pulse
    localparam int BEATS = LINE_BITS / BEAT_BITS;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF   = $clog2(LINE_BITS / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WBEAT = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    logic [2:0]           i_state_q, i_state_d, d_state_q, d_state_d;
    logic [ADDR_BITS-1:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d;
    logic [CNT_W-1:0]     i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
    logic [LINE_BITS-1:0] i_line_q, i_line_d, d_line_q, d_line_d;
    logic                 i_hold_q, i_hold_d, d_hold_q, d_hold_d;
    logic                 d_is_wr_q, d_is_wr_d;
    logic                 last_d_q, last_d_d;

    logic [ADDR_BITS-1:0] i_req_line, d_req_line;
    logic                 d_blocked, d_start, i_blocked, i_start;
    logic                 i_hit, d_hit;
    logic                 grant_i, grant_d, d_wbeat, d_wr_active;
    logic                 unused_low_bits;

    assign i_req_line = {icache_addr[ADDR_BITS-1:OFF], {OFF{1'b0}}};
    assign d_req_line = {dcache_addr[ADDR_BITS-1:OFF], {OFF{1'b0}}};
    assign unused_low_bits = ^{icache_addr[OFF-1:0], dcache_addr[OFF-1:0], bmem_raddr[OFF-1:0]};

    // Same-line requests are serialised so raddr tags stay unambiguous; D wins a simultaneous tie.
    assign d_blocked = (i_state_q != ST_IDLE) && (i_addr_q == d_req_line);
    assign d_start   = (d_state_q == ST_IDLE) && (dcache_read || dcache_write) && !d_hold_q && !d_blocked;
    assign i_blocked = ((d_state_q != ST_IDLE) && (d_addr_q == i_req_line)) ||
                       (d_start && (d_req_line == i_req_line));
    assign i_start   = (i_state_q == ST_IDLE) && icache_read && !i_hold_q && !i_blocked;

    assign i_hit = bmem_rvalid && (i_state_q == ST_WAIT) &&
                   (bmem_raddr[ADDR_BITS-1:OFF] == i_addr_q[ADDR_BITS-1:OFF]);
    assign d_hit = bmem_rvalid && (d_state_q == ST_WAIT) &&
                   (bmem_raddr[ADDR_BITS-1:OFF] == d_addr_q[ADDR_BITS-1:OFF]);

    // Alternating priority; last_d_q only moves on an accepted request so a stalled grant stays put.
    assign d_wbeat = (d_state_q == ST_WBEAT);
    assign grant_d = (d_state_q == ST_ISSUE) && ((i_state_q != ST_ISSUE) || !last_d_q);
    assign grant_i = (i_state_q == ST_ISSUE) && !d_wbeat && !grant_d;

    assign d_wr_active = (grant_d && d_is_wr_q) || d_wbeat;
    assign bmem_read   = grant_i || (grant_d && !d_is_wr_q);
    assign bmem_write  = d_wr_active;
    assign bmem_addr   = grant_i ? i_addr_q : ((grant_d || d_wbeat) ? d_addr_q : '0);
    // Write data is taken live from the client, which holds it until dcache_resp.
    assign bmem_wdata  = d_wr_active ? dcache_wdata[int'(d_cnt_q)*BEAT_BITS +: BEAT_BITS] : '0;

    assign icache_resp  = (i_state_q == ST_RESP);
    assign icache_rdata = icache_resp ? i_line_q : '0;
    assign dcache_resp  = (d_state_q == ST_RESP);
    assign dcache_rdata = (dcache_resp && !d_is_wr_q) ? d_line_q : '0;

    always_comb begin
        last_d_d = last_d_q;
        if (grant_d && bmem_ready) begin
            last_d_d = 1'b1;
        end else if (grant_i && bmem_ready) begin
            last_d_d = 1'b0;
        end
    end

    always_comb begin
        i_state_d = i_state_q;
        i_addr_d  = i_addr_q;
        i_cnt_d   = i_cnt_q;
        i_line_d  = i_line_q;
        i_hold_d  = (i_state_q == ST_RESP);
        case (i_state_q)
            ST_IDLE: begin
                if (i_start) begin
                    i_state_d = ST_ISSUE;
                    i_addr_d  = i_req_line;
                    i_cnt_d   = '0;
                end
            end
            ST_ISSUE: if (grant_i && bmem_ready) i_state_d = ST_WAIT;
            ST_WAIT: begin
                if (i_hit) begin
                    i_line_d[int'(i_cnt_q)*BEAT_BITS +: BEAT_BITS] = bmem_rdata;
                    i_cnt_d = i_cnt_q + CNT_W'(1);
                    if (i_cnt_q == LAST_BEAT) i_state_d = ST_RESP;
                end
            end
            ST_RESP: i_state_d = ST_IDLE;
            default: i_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        d_state_d = d_state_q;
        d_addr_d  = d_addr_q;
        d_cnt_d   = d_cnt_q;
        d_line_d  = d_line_q;
        d_is_wr_d = d_is_wr_q;
        d_hold_d  = (d_state_q == ST_RESP);
        case (d_state_q)
            ST_IDLE: begin
                if (d_start) begin
                    d_state_d = ST_ISSUE;
                    d_addr_d  = d_req_line;
                    d_cnt_d   = '0;
                    d_is_wr_d = dcache_write;
                end
            end
            ST_ISSUE: begin
                // A write presents beat 0 while competing, so acceptance already consumes it.
                if (grant_d && bmem_ready) begin
                    if (d_is_wr_q) begin
                        d_state_d = ST_WBEAT;
                        d_cnt_d   = CNT_W'(1);
                    end else begin
                        d_state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (d_hit) begin
                    d_line_d[int'(d_cnt_q)*BEAT_BITS +: BEAT_BITS] = bmem_rdata;
                    d_cnt_d = d_cnt_q + CNT_W'(1);
                    if (d_cnt_q == LAST_BEAT) d_state_d = ST_RESP;
                end
            end
            ST_WBEAT: begin
                if (bmem_ready) begin
                    d_cnt_d = d_cnt_q + CNT_W'(1);
                    if (d_cnt_q == LAST_BEAT) d_state_d = ST_RESP;
                end
            end
            ST_RESP: d_state_d = ST_IDLE;
            default: d_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_state_q <= ST_IDLE;
            i_addr_q  <= '0;
            i_cnt_q   <= '0;
            i_line_q  <= '0;
            i_hold_q  <= 1'b0;
            d_state_q <= ST_IDLE;
            d_addr_q  <= '0;
            d_cnt_q   <= '0;
            d_line_q  <= '0;
            d_hold_q  <= 1'b0;
            d_is_wr_q <= 1'b0;
            last_d_q  <= 1'b0;
        end else begin
            i_state_q <= i_state_d;
            i_addr_q  <= i_addr_d;
            i_cnt_q   <= i_cnt_d;
            i_line_q  <= i_line_d;
            i_hold_q  <= i_hold_d;
            d_state_q <= d_state_d;
            d_addr_q  <= d_addr_d;
            d_cnt_q   <= d_cnt_d;
            d_line_q  <= d_line_d;
            d_hold_q  <= d_hold_d;
            d_is_wr_q <= d_is_wr_d;
            last_d_q  <= last_d_d;
        end
    end

`ifdef BMEM_PERF_CNT_EN
    logic [31:0] num_icache_wait_cycles_q, num_icache_wait_cycles_d;
    logic [31:0] num_dcache_wait_cycles_q, num_dcache_wait_cycles_d;
    logic [31:0] num_icache_wait_cycles, num_dcache_wait_cycles;

    assign num_icache_wait_cycles = num_icache_wait_cycles_q;
    assign num_dcache_wait_cycles = num_dcache_wait_cycles_q;

    always_comb begin
        num_icache_wait_cycles_d = num_icache_wait_cycles_q;
        num_dcache_wait_cycles_d = num_dcache_wait_cycles_q;
        if ((i_state_q != ST_IDLE) && (num_icache_wait_cycles_q != '1)) begin
            num_icache_wait_cycles_d = num_icache_wait_cycles_q + 32'd1;
        end
        if ((d_state_q != ST_IDLE) && (num_dcache_wait_cycles_q != '1)) begin
            num_dcache_wait_cycles_d = num_dcache_wait_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_icache_wait_cycles_q <= '0;
            num_dcache_wait_cycles_q <= '0;
        end else begin
            num_icache_wait_cycles_q <= num_icache_wait_cycles_d;
            num_dcache_wait_cycles_q <= num_dcache_wait_cycles_d;
        end
    end
`else
    // Counters absent; ports and timing are unchanged.
`endif

endmodule

// File: tb/tb_bmem_line_adapter.sv
// Directed + randomized bench for bmem_line_adapter; memory contents and expected lines
// come from a line-addressed associative-array model.
`timescale 1ns/1ps

module tb_bmem_line_adapter;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  icache_addr;
    logic         icache_read;
    logic [255:0] icache_rdata;
    logic         icache_resp;
    logic [31:0]  dcache_addr;
    logic         dcache_read;
    logic         dcache_write;
    logic [255:0] dcache_wdata;
    logic [255:0] dcache_rdata;
    logic         dcache_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    bmem_line_adapter dut (
        .clk(clk), .rst(rst),
        .icache_addr(icache_addr), .icache_read(icache_read),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_addr(dcache_addr), .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_wdata(dcache_wdata), .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int i_resp_seen = 0, d_resp_seen = 0, i_resp_exp = 0, d_resp_exp = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (icache_resp) i_resp_seen++;
            if (dcache_resp) d_resp_seen++;
        end
    end

    logic [255:0] mem [logic [31:0]];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] v;
        if (!mem.exists(a)) begin
            for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom();
            mem[a] = v;
        end
        return mem[a];
    endfunction

    function automatic logic [63:0] slice(input logic [255:0] l, input int k);
        return l[64*k +: 64];
    endfunction

    task automatic beat(input logic [31:0] a, input logic [63:0] d);
        bmem_rvalid = 1'b1;
        bmem_raddr  = a;
        bmem_rdata  = d;
        tick(1);
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
        bmem_ready = 1'b1;
        tick(3);
        chk("rst_icache_resp", 256'(icache_resp), 256'(0));
        chk("rst_dcache_resp", 256'(dcache_resp), 256'(0));
        chk("rst_bmem_read", 256'(bmem_read), 256'(0));
        chk("rst_bmem_write", 256'(bmem_write), 256'(0));
        chk("rst_bmem_addr", 256'(bmem_addr), 256'(0));
        chk("rst_bmem_wdata", 256'(bmem_wdata), 256'(0));
        chk("rst_icache_rdata", icache_rdata, 256'(0));
        chk("rst_dcache_rdata", dcache_rdata, 256'(0));
        rst = 1'b0;
        tick(1);
    endtask

    // Deliver the four beats of a line (optionally with foreign-tag beats mixed in) and check the pulse.
    task automatic finish_read(input bit is_d, input logic [31:0] la, input bit junk);
        logic [255:0] l;
        l = mem_line(la);
        for (int k = 0; k < 4; k++) begin
            if (junk && ($urandom_range(0, 2) == 0))
                beat(32'hE000_0000 | ($urandom() & 32'h0FFF_FFE0), {$urandom(), $urandom()});
            beat(la, slice(l, k));
        end
        if (is_d) begin
            chk("d_resp", 256'(dcache_resp), 256'(1));
            chk("d_rdata", dcache_rdata, l);
            dcache_read = 1'b0;
            d_resp_exp++;
        end else begin
            chk("i_resp", 256'(icache_resp), 256'(1));
            chk("i_rdata", icache_rdata, l);
            icache_read = 1'b0;
            i_resp_exp++;
        end
        tick(1);
        chk("resp_one_cycle", 256'(is_d ? dcache_resp : icache_resp), 256'(0));
    endtask

    task automatic do_read(input bit is_d, input logic [31:0] la);
        bit acc;
        acc = 1'b0;
        if (is_d) begin
            dcache_addr = la | 32'($urandom_range(0, 31));
            dcache_read = 1'b1;
        end else begin
            icache_addr = la | 32'($urandom_range(0, 31));
            icache_read = 1'b1;
        end
        tick(1);
        for (int t = 0; t < 32 && !acc; t++) begin
            bmem_ready = 1'($urandom_range(0, 1));
            #1;
            if (bmem_read && bmem_ready) begin
                chk("rd_addr", 256'(bmem_addr), 256'(la));
                acc = 1'b1;
            end
            tick(1);
        end
        bmem_ready = 1'b1;
        chk("rd_accepted", 256'(acc), 256'(1));
        tick($urandom_range(0, 3));
        finish_read(is_d, la, 1'b1);
    endtask

    // Request must already be raised; streams beats until all four are consumed.
    task automatic do_write(input logic [31:0] la, input logic [255:0] wl, input bit stall1);
        int k, stall, held1;
        k = 0; stall = 0; held1 = 0;
        for (int t = 0; t < 64 && k < 4; t++) begin
            if (stall1 && k == 1 && stall < 2) begin
                bmem_ready = 1'b0;
                stall++;
            end else if (stall1) begin
                bmem_ready = 1'b1;
            end else begin
                bmem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (bmem_write) begin
                chk("wr_addr", 256'(bmem_addr), 256'(la));
                chk("wr_beat", 256'(bmem_wdata), 256'(slice(wl, k)));
                chk("wr_no_read", 256'(bmem_read), 256'(0));
                if (k == 1) held1++;
                if (bmem_ready) k++;
            end
            tick(1);
        end
        bmem_ready = 1'b1;
        chk("wr_beats", 256'(k), 256'(4));
        if (stall1) chk("wr_beat1_cycles", 256'(held1), 256'(3));
        chk("wr_resp", 256'(dcache_resp), 256'(1));
        mem[la] = wl;
        dcache_write = 1'b0;
        d_resp_exp++;
        tick(1);
        chk("wr_resp_one_cycle", 256'(dcache_resp), 256'(0));
    endtask

    task automatic do_pair(input logic [31:0] ia, input logic [31:0] da, input bit dfirst);
        logic [255:0] li, ld;
        li = mem_line(ia);
        ld = mem_line(da);
        icache_addr = ia; icache_read = 1'b1;
        dcache_addr = da; dcache_read = 1'b1;
        bmem_ready = 1'b1;
        tick(1);
        chk("pair_first_read", 256'(bmem_read), 256'(1));
        chk("pair_first_addr", 256'(bmem_addr), 256'(dfirst ? da : ia));
        tick(1);
        chk("pair_second_addr", 256'(bmem_addr), 256'(dfirst ? ia : da));
        tick(1);
        for (int k = 0; k < 4; k++) begin
            beat(ia, slice(li, k));
            if (k == 3) begin
                chk("pair_i_resp", 256'(icache_resp), 256'(1));
                chk("pair_i_rdata", icache_rdata, li);
                chk("pair_d_not_yet", 256'(dcache_resp), 256'(0));
                icache_read = 1'b0;
                i_resp_exp++;
            end
            beat(da, slice(ld, k));
            if (k == 3) begin
                chk("pair_d_resp", 256'(dcache_resp), 256'(1));
                chk("pair_d_rdata", dcache_rdata, ld);
                chk("pair_i_done", 256'(icache_resp), 256'(0));
                dcache_read = 1'b0;
                d_resp_exp++;
            end
        end
        tick(1);
        chk("pair_d_one_cycle", 256'(dcache_resp), 256'(0));
    endtask

    initial begin
        int t_req;
        logic [255:0] wl;
        logic [255:0] l7;
        logic [31:0] la;

        rst = 1'b1;
        icache_addr = '0; icache_read = 1'b0;
        dcache_addr = '0; dcache_read = 1'b0; dcache_write = 1'b0; dcache_wdata = '0;
        bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        do_reset();

        // I read, beats start three cycles after bmem_read
        void'(mem_line(32'h0000_1000));
        icache_addr = 32'h0000_101b;
        icache_read = 1'b1;
        t_req = cyc;
        tick(1);
        chk("t1_bmem_read", 256'(bmem_read), 256'(1));
        chk("t1_bmem_addr", 256'(bmem_addr), 256'(32'h0000_1000));
        tick(1);
        chk("t1_read_once", 256'(bmem_read), 256'(0));
        tick(2);
        finish_read(1'b0, 32'h0000_1000, 1'b0);
`ifdef BMEM_PERF_CNT_EN
        chk("perf_icache_wait", 256'(dut.num_icache_wait_cycles), 256'(cyc - 1 - t_req));
        chk("perf_dcache_idle", 256'(dut.num_dcache_wait_cycles), 256'(0));
`endif

        // D write with ready low for two cycles on beat 1
        for (int k = 0; k < 8; k++) wl[32*k +: 32] = $urandom();
        dcache_addr = 32'h0000_2000; dcache_wdata = wl; dcache_write = 1'b1;
        tick(1);
        chk("t2_write_latency", 256'(bmem_write), 256'(1));
        do_write(32'h0000_2000, wl, 1'b1);

        // Simultaneous misses after reset: D first, interleaved beats; then alternation
        do_reset();
        do_pair(32'h0000_1000, 32'h0000_3000, 1'b1);
        do_read(1'b1, 32'h0000_3020);
        do_pair(32'h0000_5000, 32'h0000_5020, 1'b0);

        // D write to a line the I channel is reading waits for icache_resp
        icache_addr = 32'h0000_4000; icache_read = 1'b1;
        tick(1);
        tick(1);
        for (int k = 0; k < 8; k++) wl[32*k +: 32] = $urandom();
        dcache_addr = 32'h0000_4003; dcache_wdata = wl; dcache_write = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick(1);
            chk("t4_write_blocked", 256'(bmem_write), 256'(0));
        end
        finish_read(1'b0, 32'h0000_4000, 1'b0);
        chk("t4_write_after_resp", 256'(bmem_write), 256'(0));
        tick(1);
        chk("t4_write_issues", 256'(bmem_write), 256'(1));
        do_write(32'h0000_4000, wl, 1'b0);
        do_read(1'b0, 32'h0000_4000);

        // Reset mid-read; remaining beats arrive stale
        l7 = mem_line(32'h0000_7000);
        icache_addr = 32'h0000_7000; icache_read = 1'b1;
        tick(2);
        beat(32'h0000_7000, slice(l7, 0));
        beat(32'h0000_7000, slice(l7, 1));
        do_reset();
        beat(32'h0000_7000, slice(l7, 2));
        chk("t5_stale_no_resp", 256'(icache_resp), 256'(0));
        beat(32'h0000_7000, slice(l7, 3));
        chk("t5_stale_no_resp2", 256'(icache_resp), 256'(0));
        tick(1);
        chk("t5_rdata_zero", icache_rdata, 256'(0));
        do_read(1'b0, 32'h0000_7000);

        // Randomized single-client traffic over a small line set
        for (int it = 0; it < 16; it++) begin
            la = 32'h0000_9000 + 32'(32 * $urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: do_read(1'b0, la);
                1: do_read(1'b1, la);
                default: begin
                    for (int k = 0; k < 8; k++) wl[32*k +: 32] = $urandom();
                    dcache_addr = la | 32'($urandom_range(0, 31));
                    dcache_wdata = wl; dcache_write = 1'b1;
                    tick(1);
                    do_write(la, wl, 1'b0);
                end
            endcase
            tick($urandom_range(0, 2));
        end

        tick(3);
        chk("i_resp_count", 256'(i_resp_seen), 256'(i_resp_exp));
        chk("d_resp_count", 256'(d_resp_seen), 256'(d_resp_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
